bus_serial_target: RTL and testbench



---
 rtl/bus_serial_target.sv | 175 +++++++++++++++++
 tb/tb_bus_serial_target.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_serial_target.sv
// Responder end of the serial bus link: deserializes a command frame into one OCP
// command, then serializes the slave response back. Optional parity: BUS_SERIAL_TARGET_PARITY_EN.
module bus_serial_target #(
  parameter int SERIAL_WIDTH = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ser_cmd_valid,
  input  logic [SERIAL_WIDTH-1:0]   ser_cmd_data,
`ifdef BUS_SERIAL_TARGET_PARITY_EN
  input  logic                      ser_cmd_par,
  output logic                      ser_resp_par,
`endif
  output logic                      ser_cmd_ready,
  output logic                      ser_resp_valid,
  output logic [SERIAL_WIDTH-1:0]   ser_resp_data,
  output logic [2:0]                MCmd,
  output logic [ADDR_WIDTH-1:0]     MAddr,
  output logic [DATA_WIDTH-1:0]     MData,
  output logic [DATA_WIDTH/8-1:0]   MByteEn,
  input  logic                      SCmdAccept,
  input  logic [1:0]                SResp,
  input  logic [DATA_WIDTH-1:0]     SData,
  output logic                      MRespAccept,
  output logic                      frame_drop
);
  localparam int BE_W      = DATA_WIDTH / 8;
  localparam int CMD_W     = 3 + ADDR_WIDTH + DATA_WIDTH + BE_W;
  localparam int RSP_W     = 2 + DATA_WIDTH;
  localparam int NB_CMD    = (CMD_W + SERIAL_WIDTH - 1) / SERIAL_WIDTH;
  localparam int NB_RSP    = (RSP_W + SERIAL_WIDTH - 1) / SERIAL_WIDTH;
  localparam int CMD_BITS  = NB_CMD * SERIAL_WIDTH;
  localparam int RSP_BITS  = NB_RSP * SERIAL_WIDTH;
  localparam int CMD_PAD   = CMD_BITS - CMD_W;
  localparam int RSP_PAD   = RSP_BITS - RSP_W;
  localparam int RXC_W     = $clog2(NB_CMD + 1);
  localparam int TXC_W     = $clog2(NB_RSP + 1);
  localparam logic [2:0] OCP_IDLE = 3'd0;
  localparam logic [2:0] OCP_WR   = 3'd1;
  localparam logic [2:0] OCP_RD   = 3'd2;
  localparam logic [1:0] RSP_NULL = 2'd0;
  localparam logic [1:0] RSP_ERR  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_RX, S_CMD, S_RESP, S_TX} state_t;

  state_t                state, state_nxt;
  logic [CMD_BITS-1:0]   cmd_sr;
  logic [CMD_BITS-1:0]   cmd_shift;
  logic [CMD_W-1:0]      frame;
  logic [RSP_BITS-1:0]   rsp_sr;
  logic [RSP_BITS-1:0]   rsp_load_val;
  logic                  rsp_load;
  logic [RXC_W-1:0]      rx_ctr;
  logic [TXC_W-1:0]      tx_ctr;
  logic                  beat_take;
  logic                  rx_last;
  logic                  tx_last;
  logic                  cmd_ok;
  logic [2:0]            shift_mcmd;
  logic                  frame_par_err;
  logic                  frame_drop_nxt;

  // Beats are accepted whenever ser_cmd_valid is high in S_IDLE/S_RX (ready only flags
  // frame starts); the response lane has no back-pressure, valid marks each beat.
  assign beat_take  = ser_cmd_valid && (state == S_IDLE || state == S_RX);
  assign rx_last    = beat_take && (rx_ctr == RXC_W'(NB_CMD - 1));
  assign tx_last    = (tx_ctr == TXC_W'(NB_RSP - 1));
  assign cmd_shift  = CMD_BITS'({cmd_sr, ser_cmd_data});
  assign shift_mcmd = cmd_shift[CMD_BITS-1 -: 3];
  assign cmd_ok     = (shift_mcmd == OCP_WR) || (shift_mcmd == OCP_RD);
  assign frame      = CMD_W'(cmd_sr >> CMD_PAD);

`ifdef BUS_SERIAL_TARGET_PARITY_EN
  logic par_err;
  // Error seen on any beat of the frame so far, including the one arriving now.
  assign frame_par_err = (ser_cmd_par != ^ser_cmd_data) || (state == S_RX && par_err);
  assign ser_resp_par  = ^ser_resp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          par_err <= 1'b0;
    else if (beat_take) par_err <= rx_last ? 1'b0 : frame_par_err;
  end
`else
  assign frame_par_err = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    frame_drop_nxt = 1'b0;
    rsp_load       = 1'b0;
    rsp_load_val   = '0;
    case (state)
      S_IDLE, S_RX: begin
        if (beat_take) begin
          if (!rx_last) begin
            state_nxt = S_RX;
          end else if (frame_par_err) begin
            state_nxt      = S_TX;
            rsp_load       = 1'b1;
            rsp_load_val   = RSP_BITS'({RSP_ERR, {DATA_WIDTH{1'b0}}}) << RSP_PAD;
            frame_drop_nxt = 1'b1;
          end else if (cmd_ok) begin
            state_nxt = S_CMD;
          end else begin
            state_nxt      = S_IDLE;
            frame_drop_nxt = 1'b1;
          end
        end
      end
      S_CMD:  if (SCmdAccept) state_nxt = S_RESP;
      S_RESP: begin
        if (SResp != RSP_NULL) begin
          state_nxt    = S_TX;
          rsp_load     = 1'b1;
          rsp_load_val = RSP_BITS'({SResp, SData}) << RSP_PAD;
        end
      end
      S_TX:   if (tx_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ser_cmd_ready  = 1'b0;
    ser_resp_valid = 1'b0;
    ser_resp_data  = '0;
    MCmd           = OCP_IDLE;
    MAddr          = '0;
    MData          = '0;
    MByteEn        = '0;
    MRespAccept    = 1'b0;
    case (state)
      S_IDLE: ser_cmd_ready = 1'b1;
      S_CMD: begin
        MCmd    = frame[CMD_W-1 -: 3];
        MAddr   = frame[CMD_W-4 -: ADDR_WIDTH];
        MData   = frame[DATA_WIDTH+BE_W-1 -: DATA_WIDTH];
        MByteEn = frame[BE_W-1:0];
      end
      S_RESP: MRespAccept = 1'b1;
      S_TX: begin
        ser_resp_valid = 1'b1;
        ser_resp_data  = rsp_sr[RSP_BITS-1 -: SERIAL_WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cmd_sr     <= '0;
      rsp_sr     <= '0;
      rx_ctr     <= '0;
      tx_ctr     <= '0;
      frame_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_drop <= frame_drop_nxt;
      if (beat_take) begin
        cmd_sr <= cmd_shift;
        rx_ctr <= rx_last ? '0 : rx_ctr + RXC_W'(1);
      end
      if (rsp_load) begin
        rsp_sr <= rsp_load_val;
        tx_ctr <= '0;
      end else if (state == S_TX) begin
        rsp_sr <= rsp_sr << SERIAL_WIDTH;
        tx_ctr <= tx_last ? '0 : tx_ctr + TXC_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_bus_serial_target.sv
// Bench for bus_serial_target: table of transactions, a reactive OCP slave, and a
// scoreboard of expected OCP commands and response beats checked as they appear.
module tb_bus_serial_target;
  logic        clk;
  logic        reset;
  logic        ser_cmd_valid;
  logic [3:0]  ser_cmd_data;
  logic        ser_cmd_ready;
  logic        ser_resp_valid;
  logic [3:0]  ser_resp_data;
  logic [2:0]  MCmd;
  logic [31:0] MAddr;
  logic [31:0] MData;
  logic [3:0]  MByteEn;
  logic        SCmdAccept;
  logic [1:0]  SResp;
  logic [31:0] SData;
  logic        MRespAccept;
  logic        frame_drop;
`ifdef BUS_SERIAL_TARGET_PARITY_EN
  logic        ser_cmd_par;
  logic        ser_resp_par;
`endif

  bus_serial_target dut (
    .clk(clk), .reset(reset),
    .ser_cmd_valid(ser_cmd_valid), .ser_cmd_data(ser_cmd_data),
`ifdef BUS_SERIAL_TARGET_PARITY_EN
    .ser_cmd_par(ser_cmd_par), .ser_resp_par(ser_resp_par),
`endif
    .ser_cmd_ready(ser_cmd_ready), .ser_resp_valid(ser_resp_valid), .ser_resp_data(ser_resp_data),
    .MCmd(MCmd), .MAddr(MAddr), .MData(MData), .MByteEn(MByteEn),
    .SCmdAccept(SCmdAccept), .SResp(SResp), .SData(SData),
    .MRespAccept(MRespAccept), .frame_drop(frame_drop)
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          gapped;
    int          delay;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          exp_issue;
    int          exp_drop;
  } vec_t;

  vec_t        vecs[8];
  logic [3:0]  exp_q[$];
  logic [70:0] exp_cmd_q[$];
  logic [70:0] cur_cmd;
  bit          cmd_active;
  int          n_pass, n_total;
  int          cyc, last_beat_cyc, drop_cycles;
  int          sl_delay;
  logic [1:0]  sl_resp;
  logic [31:0] sl_rdata;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  function automatic void check(string name, logic [79:0] act, logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [3:0] rsp_beat(logic [1:0] r, logic [31:0] d, int i);
    logic [35:0] w;
    w = {r, d, 2'b00};
    return w[35-4*i -: 4];
  endfunction

  function automatic logic [79:0] outs_now();
    return 80'({ser_cmd_ready, ser_resp_valid, ser_resp_data, MCmd, MAddr, MData, MByteEn,
                MRespAccept, frame_drop});
  endfunction

  // reset values: ready=1, everything else 0
  localparam logic [79:0] RESET_OUTS = 80'({1'b1, 78'h0});

  // scoreboard monitor
  always @(negedge clk) begin
    cyc++;
    if (frame_drop) drop_cycles++;
    if (MCmd != 3'd0) begin
      if (!cmd_active) begin
        if (exp_cmd_q.size() == 0) check("unexpected_mcmd", 80'(MCmd), 80'(0));
        else begin
          cur_cmd    = exp_cmd_q.pop_front();
          cmd_active = 1'b1;
        end
      end
      if (cmd_active) check("ocp_cmd", 80'({MCmd, MAddr, MData, MByteEn}), 80'(cur_cmd));
    end else begin
      cmd_active = 1'b0;
    end
    if (ser_resp_valid) begin
      if (exp_q.size() == 0) check("unexpected_resp_beat", 80'(ser_resp_valid), 80'(0));
      else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("resp_beat", 80'(ser_resp_data), 80'(e));
`ifdef BUS_SERIAL_TARGET_PARITY_EN
        check("resp_parity", 80'(ser_resp_par), 80'(^e));
`endif
        last_beat_cyc = cyc;
      end
    end
  end

  // reactive OCP slave
  initial begin
    SCmdAccept = 1'b0;
    SResp      = 2'd0;
    SData      = '0;
    forever begin
      @(negedge clk);
      if (MCmd != 3'd0 && !reset) begin
        repeat (sl_delay) @(negedge clk);
        SCmdAccept = 1'b1;
        @(negedge clk);
        SCmdAccept = 1'b0;
        for (int k = 0; k < 50 && !MRespAccept; k++) @(negedge clk);
        SResp = sl_resp;
        SData = sl_rdata;
        @(negedge clk);
        SResp = 2'd0;
        SData = '0;
      end
    end
  end

  // driver tasks
  task automatic drive_beat(input logic [71:0] f, input int i, input int bad_beat);
    ser_cmd_valid = 1'b1;
    ser_cmd_data  = f[71-4*i -: 4];
`ifdef BUS_SERIAL_TARGET_PARITY_EN
    ser_cmd_par   = (^ser_cmd_data) ^ (i == bad_beat);
`else
    if (bad_beat > 17) ser_cmd_data = ser_cmd_data;
`endif
  endtask

  task automatic send_frame(input logic [71:0] f, input bit gapped, input int bad_beat);
    for (int i = 0; i < 18; i++) begin
      if (gapped && i > 0) begin
        @(negedge clk);
        ser_cmd_valid = 1'b0;
        ser_cmd_data  = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      drive_beat(f, i, bad_beat);
    end
    @(negedge clk);
    ser_cmd_valid = 1'b0;
    ser_cmd_data  = '0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    #1;
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && exp_cmd_q.size() == 0 && ser_cmd_ready && !ser_resp_valid) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("wait_done", 80'(done), 80'(1));
  endtask

  task automatic expect_txn(input vec_t v);
    if (v.exp_issue) begin
      exp_cmd_q.push_back({v.cmd, v.addr, v.data, v.be});
      for (int i = 0; i < 9; i++) exp_q.push_back(rsp_beat(v.resp, v.rdata, i));
    end
    sl_delay = v.delay;
    sl_resp  = v.resp;
    sl_rdata = v.rdata;
  endtask

  task automatic run_vector(input vec_t v);
    int d0;
    d0 = drop_cycles;
    expect_txn(v);
    send_frame({v.cmd, v.addr, v.data, v.be, 1'b0}, v.gapped, -1);
    check("mcmd_latency", 80'(MCmd), 80'(v.exp_issue ? v.cmd : 3'd0));
    if (!v.exp_issue) check("ready_after_drop", 80'(ser_cmd_ready), 80'(1));
    wait_done();
    if (v.exp_issue) check("ready_after_tx", 80'(cyc - last_beat_cyc), 80'(1));
    check("frame_drop_cycles", 80'(drop_cycles - d0), 80'(v.exp_drop));
  endtask

  task automatic do_reset(input string name);
    #1 reset = 1'b1;
    #1 check(name, outs_now(), RESET_OUTS);
    exp_q.delete();
    exp_cmd_q.delete();
    @(negedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vec_t rd_clean;
    logic [71:0] f;
    n_pass = 0; n_total = 0; cyc = 0; last_beat_cyc = 0; drop_cycles = 0;
    cmd_active = 1'b0;
    sl_delay = 0; sl_resp = 2'd1; sl_rdata = '0;
    reset = 1'b1;
    ser_cmd_valid = 1'b0;
    ser_cmd_data  = '0;
`ifdef BUS_SERIAL_TARGET_PARITY_EN
    ser_cmd_par   = 1'b0;
`endif
    //         cmd    addr          data           be    gap dly resp   rdata          iss drop
    vecs[0] = '{3'd1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 3, 2'd1, 32'h0,          1, 0};
    vecs[1] = '{3'd2, 32'h0000_0020, 32'h0,         4'hF, 0, 1, 2'd1, 32'h1234_5678,  1, 0};
    vecs[2] = '{3'd1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1, 0, 2'd1, 32'h0,          1, 0};
    vecs[3] = '{3'd5, 32'h0000_0044, 32'h5555_AAAA, 4'hF, 0, 0, 2'd1, 32'h0,          0, 1};
    vecs[4] = '{3'd2, $urandom,      $urandom,      4'hF, 0, $urandom_range(0, 4), 2'd3, $urandom, 1, 0};
    vecs[5] = '{3'd1, $urandom,      $urandom,      4'h3, 0, $urandom_range(0, 4), 2'd2, 32'h0,    1, 0};
    vecs[6] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 1, 0, 2'd1, 32'h0,          0, 1};
    vecs[7] = '{3'd2, $urandom,      32'h0,         4'hF, 1, $urandom_range(0, 4), 2'd1, $urandom, 1, 0};
    rd_clean = vecs[1];

    repeat (3) @(negedge clk);
    #1 check("reset_values", outs_now(), RESET_OUTS);
    reset = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 8; n++) run_vector(vecs[n]);

    // reset with beats 0..7 of a frame already taken
    f = {3'd2, 32'h40, 32'h0, 4'hF, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_beat(f, i, -1);
    end
    @(negedge clk);
    ser_cmd_valid = 1'b0;
    do_reset("reset_mid_frame");
    run_vector(rd_clean);

    // reset while response beat 4 is on the lane
    expect_txn(rd_clean);
    send_frame({rd_clean.cmd, rd_clean.addr, rd_clean.data, rd_clean.be, 1'b0}, 1'b0, -1);
    for (int k = 0; k < 100 && exp_q.size() > 4; k++) begin
      @(negedge clk);
      #1;
    end
    check("tx_progress", 80'(exp_q.size()), 80'(4));
    do_reset("reset_mid_tx");
    run_vector(rd_clean);

`ifdef BUS_SERIAL_TARGET_PARITY_EN
    begin
      int d0;
      d0 = drop_cycles;
      for (int i = 0; i < 9; i++) exp_q.push_back(rsp_beat(2'd3, 32'h0, i));
      send_frame({3'd2, 32'h80, 32'h0, 4'hF, 1'b0}, 1'b0, 3);
      check("par_no_mcmd", 80'(MCmd), 80'(0));
      wait_done();
      check("par_frame_drop", 80'(drop_cycles - d0), 80'(1));
    end
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
